// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: score entry layout, sequencer
// state encoding and the pitch divider values for the supported notes.
package synth_pkg;

    localparam int ENTRY_W   = 24;
    localparam int DIV_W     = 11;
    localparam int DELTA_W   = 8;

    localparam int DIV_LSB   = 0;
    localparam int DIV_MSB   = 10;
    localparam int GATE_BIT  = 11;
    localparam int END_BIT   = 12;
    localparam int RSV_LSB   = 13;
    localparam int RSV_MSB   = 15;
    localparam int DELTA_LSB = 16;
    localparam int DELTA_MSB = 23;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WAIT
    } seq_state_e;

    // Divider values for the 64 MHz voice clock.
    localparam logic [DIV_W-1:0] TONE_G3 = 11'd318;
    localparam logic [DIV_W-1:0] TONE_A3 = 11'd283;
    localparam logic [DIV_W-1:0] TONE_B3 = 11'd252;
    localparam logic [DIV_W-1:0] TONE_C4 = 11'd238;
    localparam logic [DIV_W-1:0] TONE_D4 = 11'd212;
    localparam logic [DIV_W-1:0] TONE_E4 = 11'd189;
    localparam logic [DIV_W-1:0] TONE_F4 = 11'd178;
    localparam logic [DIV_W-1:0] TONE_G4 = 11'd159;

endpackage

// File: rtl/seq_tick_timer.sv
// Note-duration down-counter. Ticks seen while the sequencer is fetching are
// held in a one-deep pending latch and credited on the first counting cycle.
module seq_tick_timer
    import synth_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               load,
    input  logic [DELTA_W-1:0] load_val,
    input  logic               tick,
    input  logic               clr,
    input  logic               count,
    output logic               expire
);

    logic [DELTA_W-1:0] remaining_q, remaining_d;
    logic               tick_pend_q, tick_pend_d;
    logic [1:0]         credits;

    assign credits = 2'(tick_pend_q) + 2'(tick);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        remaining_d = remaining_q;
        tick_pend_d = tick_pend_q;
        expire      = 1'b0;
        if (clr) begin
            remaining_d = '0;
            tick_pend_d = 1'b0;
        end else if (load) begin
            remaining_d = load_val;
            tick_pend_d = tick_pend_q | tick;
        end else if (count) begin
            tick_pend_d = 1'b0;
            if (credits != 2'd0) begin
                if (remaining_q <= DELTA_W'(credits)) begin
                    remaining_d = '0;
                    expire      = 1'b1;
                end else begin
                    remaining_d = remaining_q - DELTA_W'(credits);
                end
            end
        end else if (tick) begin
            tick_pend_d = 1'b1;
        end
    end

    // NOTE: reset is sampled on the clock edge here, so it lives inside the clocked branch.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            remaining_q <= '0;
            tick_pend_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            remaining_q <= remaining_d;
            tick_pend_q <= tick_pend_d;
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// Plays note entries from the score ROM on tempo ticks and drives the voice
// pitch divider and output-enable gate.
module score_sequencer
    import synth_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 9,
    parameter int unsigned       START_ADDR  = 0,
    parameter logic [DIV_W-1:0]  DEFAULT_DIV = TONE_C4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                tick,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    output logic [ADDR_W-1:0]   score_addr,
    input  logic [ENTRY_W-1:0]  score_data,
    output logic                gate,
    output logic [DIV_W-1:0]    div_num,
    output logic                note_strobe,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                gate_q, gate_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;
    logic                load, clr, count, expire;

    logic [DIV_W-1:0]    entry_div;
    logic                entry_gate, entry_end;
    logic [DELTA_W-1:0]  entry_delta;
    logic                unused_reserved;

    assign entry_div       = score_data[DIV_MSB:DIV_LSB];
    assign entry_gate      = score_data[GATE_BIT];
    assign entry_end       = score_data[END_BIT];
    assign entry_delta     = score_data[DELTA_MSB:DELTA_LSB];
    assign unused_reserved = ^score_data[RSV_MSB:RSV_LSB];

    assign count = (state_q == S_WAIT);

    seq_tick_timer u_timer (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (load),
        .load_val (entry_delta),
        .tick     (tick),
        .clr      (clr),
        .count    (count),
        .expire   (expire)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        gate_d   = gate_q;
        div_d    = div_q;
        strobe_d = 1'b0;
        done_d   = done_q;
        load     = 1'b0;
        clr      = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            gate_d  = 1'b0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Holding the timer clear in IDLE also discards idle ticks.
                    clr = 1'b1;
                    if (start) begin
                        addr_d  = START;
                        done_d  = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    if (entry_end) begin
                        if (loop_en) begin
                            addr_d  = START;
                            state_d = S_FETCH;
                        end else begin
                            gate_d  = 1'b0;
                            done_d  = 1'b1;
                            clr     = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        gate_d   = entry_gate;
                        div_d    = entry_div;
                        strobe_d = 1'b1;
                        load     = 1'b1;
                        if (entry_delta == '0) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (expire) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            addr_q   <= START;
            gate_q   <= 1'b0;
            div_q    <= DEFAULT_DIV;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            gate_q   <= gate_d;
            div_q    <= div_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign score_addr  = addr_q;
    assign gate        = gate_q;
    assign div_num     = div_q;
    assign note_strobe = strobe_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer: directed scenarios plus random scores
// compared against a timeline model of note applications.
module tb_score_sequencer;
    import synth_pkg::*;

    localparam int TMAX = 16384;
    localparam logic [23:0] END_ENTRY = 24'h001000;

    logic        CLK = 1'b0, nRST = 1'b0, tick = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [8:0]  score_addr;
    logic [23:0] score_data;
    logic        gate, note_strobe, busy, done;
    logic [10:0] div_num;

    logic [23:0] rom [512];
    bit          tick_at [TMAX];

    typedef struct {int edge_n; int div; int gate;} ev_t;
    ev_t got_q[$];
    ev_t exp_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) score_data <= rom[score_addr];

    score_sequencer dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .tick        (tick),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .score_addr  (score_addr),
        .score_data  (score_data),
        .gate        (gate),
        .div_num     (div_num),
        .note_strobe (note_strobe),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock: present this edge's tick, wait for the edge, sample 1 time unit later.
    task automatic step();
        tick = tick_at[cyc + 1];
        @(posedge CLK);
        cyc++;
        #1;
        if (note_strobe === 1'b1) got_q.push_back('{cyc, int'(div_num), int'(gate)});
    endtask

    task automatic clear_ticks();
        for (int i = cyc + 1; i < TMAX; i++) tick_at[i] = 1'b0;
    endtask

    task automatic rand_ticks(input int from, input int to);
        int t;
        t = from + int'($urandom_range(1, 6));
        while (t < to) begin
            tick_at[t] = 1'b1;
            t += int'($urandom_range(3, 7));
        end
    endtask

    // Timeline model: start sampled at edge k; each entry is applied two edges after
    // its fetch begins; ticks during fetch/decode are remembered once and credited
    // on the first wait edge; an entry with delta d lets the next fetch begin at
    // the edge of its d-th credited tick.
    task automatic model(input int k, input bit lp, input int lim, output int done_e);
        int fe, e, addr, rem, c, d;
        bit pend, fin;
        logic [23:0] w;
        fe = k; addr = 0; pend = 1'b0; done_e = -1;
        exp_q.delete();
        while (fe + 2 <= lim) begin
            e = fe + 2;
            w = rom[addr];
            pend = pend | tick_at[fe + 1] | tick_at[e];
            if (w[12]) begin
                if (lp) begin
                    addr = 0;
                    fe = e;
                    continue;
                end
                done_e = e;
                break;
            end
            exp_q.push_back('{e, int'(w[10:0]), int'(w[11])});
            if (w[23:16] == 8'd0) begin
                addr = (addr + 1) % 512;
                fe = e;
                continue;
            end
            rem = int'(w[23:16]);
            c = e;
            fin = 1'b0;
            while (!fin && c < lim) begin
                c++;
                d = int'(tick_at[c]) + ((c == e + 1) ? int'(pend) : 0);
                if (c == e + 1) pend = 1'b0;
                if (d >= rem) fin = 1'b1;
                else rem -= d;
            end
            if (!fin) break;
            fe = c;
            addr = (addr + 1) % 512;
        end
    endtask

    task automatic play(input string tag, input bit lp, input int lim, input bit rnd);
        int k, done_e, done_got;
        k = cyc + 1;
        if (rnd) begin
            clear_ticks();
            rand_ticks(k, k + lim);
        end
        model(k, lp, k + lim, done_e);
        got_q.delete();
        loop_en = lp;
        start = 1'b1;
        step();
        start = 1'b0;
        if (lp) begin
            while (cyc < k + lim) step();
            stop = 1'b1;
            step();
            stop = 1'b0;
            check({tag, "_stop_busy"}, busy, 0);
            check({tag, "_stop_gate"}, gate, 0);
            check({tag, "_stop_done"}, done, 0);
        end else begin
            while (busy && cyc < k + lim) step();
            done_got = busy ? -1 : cyc;
            check({tag, "_done_edge"}, done_got, done_e);
            check({tag, "_done"}, done, (done_e >= 0) ? 1 : 0);
            check({tag, "_end_gate"}, gate, 0);
        end
        check({tag, "_n_strobes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_ev%0d_edge", tag, i), got_q[i].edge_n, exp_q[i].edge_n);
            check($sformatf("%s_ev%0d_div", tag, i), got_q[i].div, exp_q[i].div);
            check($sformatf("%s_ev%0d_gate", tag, i), got_q[i].gate, exp_q[i].gate);
        end
    endtask

    function automatic logic [23:0] note(input int delta, input bit g, input logic [10:0] dv);
        return {8'(delta), 3'b000, 1'b0, g, dv};
    endfunction

    initial begin
        int k, n;
        bit lp;
        for (int i = 0; i < 512; i++) rom[i] = END_ENTRY;

        // Reset values
        nRST = 1'b0;
        step();
        step();
        check("rst_gate", gate, 0);
        check("rst_div", div_num, 238);
        check("rst_strobe", note_strobe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", score_addr, 0);
        nRST = 1'b1;
        step();

        // Two held notes then a non-looping end
        rom[0] = note(6, 1'b1, TONE_G3);
        rom[1] = note(3, 1'b1, TONE_E4);
        rom[2] = END_ENTRY;
        play("tp1", 1'b0, 400, 1'b1);
        check("tp1_first_div", (got_q.size() > 0) ? got_q[0].div : -1, 318);
        check("tp1_final_div", div_num, 189);
        check("tp1_busy", busy, 0);

        // Back-to-back delta=0 entries
        rom[0] = note(0, 1'b1, TONE_C4);
        rom[1] = note(0, 1'b0, TONE_D4);
        rom[2] = note(2, 1'b1, TONE_E4);
        rom[3] = END_ENTRY;
        play("tp2", 1'b0, 400, 1'b1);
        check("tp2_spacing", (got_q.size() > 1) ? got_q[1].edge_n - got_q[0].edge_n : -1, 2);
        check("tp2_last_gate", (got_q.size() > 2) ? got_q[2].gate : -1, 1);
        check("tp2_final_div", div_num, 189);

        // Looping two-entry score
        rom[0] = note(1, 1'b1, TONE_C4);
        rom[1] = note(2, 1'b1, TONE_E4);
        rom[2] = END_ENTRY;
        play("tp3", 1'b1, 150, 1'b1);
        check("tp3_repeat_div", (got_q.size() > 2) ? got_q[2].div : -1, 238);

        // Stop during WAIT with four ticks still to go, then replay
        rom[0] = note(6, 1'b1, TONE_E4);
        rom[1] = note(1, 1'b1, TONE_D4);
        rom[2] = END_ENTRY;
        clear_ticks();
        k = cyc + 1;
        tick_at[k + 4] = 1'b1;
        tick_at[k + 8] = 1'b1;
        got_q.delete();
        loop_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("tp4_gate", gate, 0);
        check("tp4_busy", busy, 0);
        check("tp4_div_held", div_num, 189);
        check("tp4_done", done, 0);
        check("tp4_strobes", got_q.size(), 1);
        play("tp4_replay", 1'b0, 400, 1'b1);

        // Tick on the DECODE edge of a delta=1 entry
        rom[0] = note(1, 1'b1, TONE_D4);
        rom[1] = note(1, 1'b1, TONE_E4);
        rom[2] = END_ENTRY;
        clear_ticks();
        k = cyc + 1;
        tick_at[k + 2] = 1'b1;
        tick_at[k + 9] = 1'b1;
        play("tp5", 1'b0, 60, 1'b0);
        check("tp5_gap", (got_q.size() > 1) ? got_q[1].edge_n - got_q[0].edge_n : -1, 3);

        // Reset asserted during WAIT while start is high
        rom[0] = note(5, 1'b1, TONE_G3);
        rom[1] = END_ENTRY;
        clear_ticks();
        loop_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        nRST = 1'b0;
        start = 1'b1;
        step();
        check("tp6_gate", gate, 0);
        check("tp6_div", div_num, 238);
        check("tp6_strobe", note_strobe, 0);
        check("tp6_busy", busy, 0);
        check("tp6_done", done, 0);
        check("tp6_addr", score_addr, 0);
        nRST = 1'b1;
        start = 1'b0;
        got_q.delete();
        repeat (4) step();
        check("tp6_idle_busy", busy, 0);
        check("tp6_idle_strobes", got_q.size(), 0);
        play("tp6_resume", 1'b0, 400, 1'b1);

        // Address wrap across the full ROM
        for (int i = 0; i < 512; i++) rom[i] = {8'd0, 3'b101, 1'b0, i[0], 11'(i)};
        play("wrap", 1'b1, 1040, 1'b1);
        check("wrap_div_after_511", (got_q.size() > 512) ? got_q[512].div : -1, 0);
        for (int i = 0; i < 512; i++) rom[i] = END_ENTRY;

        // Random scores
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++)
                rom[i] = {8'($urandom_range(0, 3)), 3'($urandom), 1'b0, 1'($urandom), 11'($urandom)};
            rom[n] = 24'($urandom) | END_ENTRY;
            lp = 1'($urandom);
            play($sformatf("rnd%0d", r), lp, lp ? 150 : 400, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
Plays a note score stored in a 512x24 score ROM and drives the voice pitch divider and output-enable gate of the wavetable voice. Replaces hard-coded per-tick case statements in the top level. Sits between the tempo tick divider (about 12 Hz strobe) and the divider_variable / RAM voice path. Runs entirely in the 64 MHz voice clock domain.

Parameters:
ADDR_W, 9, score ROM address width
START_ADDR, 0, first score entry fetched on start or on loop
DEFAULT_DIV, 11'd238, div_num value after reset (C4)

Ports:
CLK  in  1  system clock; all logic on posedge
nRST  in  1  reset, synchronous, active-low
tick  in  1  one-CLK-cycle tempo strobe
start  in  1  level; sampled high in IDLE begins playback
stop  in  1  level; aborts playback, highest priority
loop_en  in  1  at end marker: 1 restarts at START_ADDR, 0 finishes
score_addr  out  ADDR_W  score ROM address (registered)
score_data  in  24  ROM read data, valid one cycle after address is presented
gate  out  1  voice output enable (OE)
div_num  out  11  pitch divider value to divider_variable
note_strobe  out  1  one-cycle pulse each time a non-end entry is applied
busy  out  1  high in every state except IDLE
done  out  1  set on non-looping end marker; cleared by next start or reset

Behaviour:
- Entry format: [10:0] div; [11] gate; [12] end marker; [15:13] reserved, ignored; [23:16] delta, the number of ticks the entry holds before the next fetch.
- Reset (nRST low at posedge) sets:
  - state=IDLE, score_addr=START_ADDR
  - gate=0, div_num=DEFAULT_DIV
  - note_strobe=0, busy=0, done=0
  - remaining=0, tick_pend=0
- States: IDLE, FETCH, DECODE, WAIT.
- IDLE:
  - start=1 (and stop=0): score_addr<=START_ADDR, done<=0, next FETCH.
  - tick is ignored.
- FETCH: one cycle; the address is stable while the ROM registers it. Next DECODE.
- DECODE (score_data valid):
  - end=1, loop_en=1: score_addr<=START_ADDR, next FETCH. gate and div_num unchanged.
  - end=1, loop_en=0: gate<=0, done<=1, next IDLE.
  - end=0: gate<=score_data[11], div_num<=score_data[10:0], note_strobe<=1 for one cycle, remaining<=delta.
    - delta=0: score_addr<=score_addr+1, next FETCH. This lets several entries apply back-to-back, 2 cycles apart.
    - delta>0: next WAIT.
- WAIT:
  - A tick, or a pending tick, decrements remaining.
  - When the decrement takes remaining from 1 to 0: score_addr<=score_addr+1, next FETCH.
- Tick pending:
  - A tick arriving in FETCH or DECODE sets tick_pend; no tick is lost while busy.
  - tick_pend is consumed on the first WAIT cycle, and also counts there if tick=1 in that same cycle.
  - A second tick arriving while tick_pend is already set is dropped. Impossible at the specified tick rate.
  - tick_pend is cleared on entry to IDLE.
- Latency: start sampled at edge k gives new gate/div_num and note_strobe at edge k+2. The next fetch begins the cycle after the final counted tick.
- stop=1 in any state forces:
  - gate<=0, state<=IDLE, tick_pend<=0
  - done unchanged
  - div_num holds its value
- Priority: stop over start. start while busy is ignored.
- Address wraps modulo 2^ADDR_W; wrap is not an error.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Shared package synth_pkg:
  - entry field positions and widths (DIV_LSB/MSB, GATE_BIT, END_BIT, DELTA_LSB/MSB)
  - state encoding
  - the tone_* divider constants, currently duplicated in the top level
- One sub-module, seq_tick_timer: remaining down-counter plus tick_pend latch.
  - Inputs: load, load_val, tick, clr.
  - Output: expire, a one-cycle pulse.

Test Plan:
- Reset with score {G3 gate=1 delta=6; E4 gate=1 delta=3; end}, loop_en=0; pulse start -> at start+2 cycles div_num=318, gate=1, note_strobe pulse. After the 6th tick, div_num=189. After 3 more ticks, gate=0, done=1, busy=0.
- Score entries with delta=0: {C4 gate=1 d0; D4 gate=0 d0; E4 gate=1 d2} -> note_strobe fires 3 times, 2 cycles apart; final div_num=189, gate=1.
- loop_en=1 with 2-entry score -> score_addr returns to START_ADDR after the end marker; done stays 0; second pass repeats the same div_num sequence.
- Assert stop mid-WAIT with remaining=4 -> next cycle gate=0, busy=0, div_num held, done=0. A new start replays from entry 0.
- Tick coincident with the DECODE cycle of an entry with delta=1 -> tick_pend consumed in WAIT; next fetch begins without waiting for another tick.
- Drive nRST low during WAIT while start=1 -> all outputs return to reset values at that edge. Playback does not resume until nRST is high and start is sampled in IDLE.
